// File: rtl/field_edit_controller_pkg.sv
// Shared definitions for the manual time-setting controller: field codes,
// field limits, FSM encoding and the wrap-around step helpers.
package field_edit_controller_pkg;

  localparam logic [1:0] FIELD_HORA = 2'd0;
  localparam logic [1:0] FIELD_MIN  = 2'd1;
  localparam logic [1:0] FIELD_SEG  = 2'd2;

  localparam logic [4:0] MAX_HORA = 5'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EDIT   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Hours step with wrap 23<->0; out-of-range values fold back into range.
  function automatic logic [4:0] wrap_hora(input logic [4:0] v, input logic up);
    if (up) begin
      return (v >= MAX_HORA) ? 5'd0 : v + 5'd1;
    end else begin
      return ((v == 5'd0) || (v > MAX_HORA)) ? MAX_HORA : v - 5'd1;
    end
  endfunction

  // Minutes/seconds step with wrap 59<->0.
  function automatic logic [5:0] wrap_sexa(input logic [5:0] v, input logic up);
    if (up) begin
      return (v >= MAX_MIN) ? 6'd0 : v + 6'd1;
    end else begin
      return ((v == 6'd0) || (v > MAX_MIN)) ? MAX_MIN : v - 6'd1;
    end
  endfunction

endpackage

// File: rtl/field_edit_controller_repeat_pulse.sv
// Press-plus-auto-repeat generator for one up/down button. Emits a registered
// one-cycle step on the press edge, again DELAY cycles after the press, then
// every RATE cycles while the button stays held. A held partner button (hold)
// or a disabled block keeps both counters at zero. DELAY must be at least 2.
module repeat_pulse #(
  parameter int DELAY = 50_000_000,
  parameter int RATE  = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic level,
  input  logic hold,
  output logic step
);

  localparam int CW = $clog2(((DELAY > RATE) ? DELAY : RATE) + 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(RATE);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic          prev;
  logic [CW-1:0] delay_cnt;
  logic [CW-1:0] rate_cnt;
  logic          press;

  assign press = level & ~prev;

  // Edge detect, delay phase then rate phase; a zero counter means that phase is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev      <= 1'b0;
      step      <= 1'b0;
      delay_cnt <= '0;
      rate_cnt  <= '0;
    end else begin
      prev <= level;
      if (!en || !level || hold) begin
        step      <= 1'b0;
        delay_cnt <= '0;
        rate_cnt  <= '0;
      end else if (press) begin
        step      <= 1'b1;
        delay_cnt <= CNT_ONE;
        rate_cnt  <= '0;
      end else if (delay_cnt != '0) begin
        if (delay_cnt == DELAY_LAST) begin
          step      <= 1'b1;
          delay_cnt <= '0;
          rate_cnt  <= CNT_ONE;
        end else begin
          step      <= 1'b0;
          delay_cnt <= delay_cnt + CNT_ONE;
        end
      end else if (rate_cnt != '0) begin
        if (rate_cnt == RATE_LAST) begin
          step     <= 1'b1;
          rate_cnt <= CNT_ONE;
        end else begin
          step     <= 1'b0;
          rate_cnt <= rate_cnt + CNT_ONE;
        end
      end else begin
        step <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/field_edit_controller.sv
// Manual time-setting sequencer: loads a shadow copy of the running time,
// lets the user move between fields and step them, then strobes wr_en so the
// counters take the edited value.
module field_edit_controller
  import field_edit_controller_pkg::*;
#(
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int BLINK_HALF   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       edit_en,
  input  logic       aumento,
  input  logic       disminuye,
  input  logic       derecha,
  input  logic       izquierda,
  input  logic [4:0] hora_in,
  input  logic [5:0] min_in,
  input  logic [5:0] seg_in,
  output logic [1:0] field_sel,
  output logic [4:0] hora_out,
  output logic [5:0] min_out,
  output logic [5:0] seg_out,
  output logic       wr_en,
  output logic       blink
);

  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

  state_t          state, state_next;
  logic            in_edit;
  logic            der_prev, izq_prev;
  logic            der_ev, izq_ev;
  logic            step_up, step_dn;
  logic            do_step, field_move;
  logic [1:0]      field_nxt;
  logic [4:0]      hora_nxt;
  logic [5:0]      min_nxt, seg_nxt;
  logic [BW-1:0]   blink_cnt;

  assign in_edit = (state == EDIT);

  repeat_pulse #(.DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE)) u_rep_up (
    .clk(clk), .rst(rst), .en(in_edit), .level(aumento), .hold(disminuye), .step(step_up)
  );

  repeat_pulse #(.DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE)) u_rep_dn (
    .clk(clk), .rst(rst), .en(in_edit), .level(disminuye), .hold(aumento), .step(step_dn)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: edit_en drop in EDIT always goes through COMMIT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = edit_en ? LOAD : IDLE;
      LOAD:    state_next = EDIT;
      EDIT:    state_next = edit_en ? EDIT : COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next shadow values and field: the step uses the old field, then the field moves.
  always_comb begin
    hora_nxt   = hora_out;
    min_nxt    = min_out;
    seg_nxt    = seg_out;
    field_nxt  = field_sel;
    field_move = 1'b0;
    do_step    = step_up ^ step_dn;
    if (do_step) begin
      case (field_sel)
        FIELD_HORA: hora_nxt = wrap_hora(hora_out, step_up);
        FIELD_MIN:  min_nxt  = wrap_sexa(min_out, step_up);
        FIELD_SEG:  seg_nxt  = wrap_sexa(seg_out, step_up);
        default:    hora_nxt = hora_out;
      endcase
    end else begin
      hora_nxt = hora_out;
    end
    if (der_ev && !izq_ev) begin
      field_move = 1'b1;
      field_nxt  = (field_sel >= FIELD_SEG) ? FIELD_HORA : field_sel + 2'd1;
    end else if (izq_ev && !der_ev) begin
      field_move = 1'b1;
      field_nxt  = (field_sel == FIELD_HORA) ? FIELD_SEG : field_sel - 2'd1;
    end else begin
      field_move = 1'b0;
    end
  end

  // Registered field/shadow datapath, field-button edge detection and write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      der_prev  <= 1'b0;
      izq_prev  <= 1'b0;
      der_ev    <= 1'b0;
      izq_ev    <= 1'b0;
      wr_en     <= 1'b0;
      field_sel <= FIELD_HORA;
      hora_out  <= 5'd0;
      min_out   <= 6'd0;
      seg_out   <= 6'd0;
    end else begin
      der_prev <= derecha;
      izq_prev <= izquierda;
      der_ev   <= in_edit & derecha & ~der_prev;
      izq_ev   <= in_edit & izquierda & ~izq_prev;
      wr_en    <= (state == COMMIT);
      if (state == LOAD) begin
        field_sel <= FIELD_HORA;
        hora_out  <= hora_in;
        min_out   <= min_in;
        seg_out   <= seg_in;
      end else begin
        field_sel <= field_nxt;
        hora_out  <= hora_nxt;
        min_out   <= min_nxt;
        seg_out   <= seg_nxt;
      end
    end
  end

  // Blink generator: solid outside EDIT, restarts solid on any edit activity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (!in_edit || do_step || field_move) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink     <= ~blink;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BLINK_ONE;
    end
  end

endmodule

// File: tb/tb_field_edit_controller.sv
// Directed plus randomized bench for field_edit_controller with a field-level
// reference model (modular arithmetic on hours/minutes/seconds and the field).
module tb_field_edit_controller;

  localparam int D = 8;
  localparam int R = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       edit_en = 1'b0;
  logic       aumento = 1'b0, disminuye = 1'b0, derecha = 1'b0, izquierda = 1'b0;
  logic [4:0] hora_in = 5'd0;
  logic [5:0] min_in = 6'd0, seg_in = 6'd0;
  logic [1:0] field_sel;
  logic [4:0] hora_out;
  logic [5:0] min_out, seg_out;
  logic       wr_en, blink;

  int tests = 0, fails = 0;
  int wr_cnt = 0, exp_wr = 0;
  int mh = 0, mm = 0, ms = 0, mf = 0;

  field_edit_controller #(.REPEAT_DELAY(D), .REPEAT_RATE(R), .BLINK_HALF(H)) dut (
    .clk(clk), .rst(rst), .edit_en(edit_en),
    .aumento(aumento), .disminuye(disminuye), .derecha(derecha), .izquierda(izquierda),
    .hora_in(hora_in), .min_in(min_in), .seg_in(seg_in),
    .field_sel(field_sel), .hora_out(hora_out), .min_out(min_out), .seg_out(seg_out),
    .wr_en(wr_en), .blink(blink)
  );

  always #5 clk = ~clk;

  // Count write strobes, sampled mid-cycle.
  always @(negedge clk) if (wr_en === 1'b1) wr_cnt++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic blink_exp(input int k);
    return ((k / H) % 2) == 0;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_field"}, field_sel, mf);
    chk({tag, "_hora"}, hora_out, mh);
    chk({tag, "_min"}, min_out, mm);
    chk({tag, "_seg"}, seg_out, ms);
  endtask

  // mask bits: 0 aumento, 1 disminuye, 2 derecha, 3 izquierda
  task automatic press(input int mask);
    aumento = mask[0]; disminuye = mask[1]; derecha = mask[2]; izquierda = mask[3];
    tick(1);
    aumento = 1'b0; disminuye = 1'b0; derecha = 1'b0; izquierda = 1'b0;
    tick(1);
  endtask

  // Reference: one press applies the step to the current field, then moves the field.
  task automatic model_press(input int mask);
    bit a, d, r, l;
    a = mask[0]; d = mask[1]; r = mask[2]; l = mask[3];
    if (a != d) begin
      if (mf == 0) mh = (mh + (a ? 1 : 23)) % 24;
      else if (mf == 1) mm = (mm + (a ? 1 : 59)) % 60;
      else ms = (ms + (a ? 1 : 59)) % 60;
    end
    if (r != l) mf = r ? (mf + 1) % 3 : (mf + 2) % 3;
  endtask

  task automatic do_press(input int mask, input string tag);
    press(mask);
    model_press(mask);
    check_model(tag);
  endtask

  task automatic enter_edit(input int h, input int m, input int s);
    hora_in = 5'(h); min_in = 6'(m); seg_in = 6'(s);
    edit_en = 1'b1;
    tick(2);
    mh = h; mm = m; ms = s; mf = 0;
  endtask

  task automatic leave_edit(input string tag);
    edit_en = 1'b0;
    tick(1);
    chk({tag, "_wr_before"}, wr_en, 0);
    tick(1);
    chk({tag, "_wr_pulse"}, wr_en, 1);
    check_model({tag, "_during_wr"});
    tick(1);
    chk({tag, "_wr_after"}, wr_en, 0);
    exp_wr++;
    chk({tag, "_wr_count"}, wr_cnt, exp_wr);
    check_model({tag, "_idle"});
    chk({tag, "_blink_idle"}, blink, 1);
  endtask

  initial begin
    int cnt;
    int masks[6];
    masks = '{1, 2, 4, 8, 3, 12};

    // Reset values
    #2 rst = 1'b0;
    #2;
    check_model("reset");
    chk("reset_wr", wr_en, 0);
    chk("reset_blink", blink, 1);
    tick(2);
    check_model("reset_held");
    rst = 1'b1;
    tick(1);

    // Load / commit
    hora_in = 5'd12; min_in = 6'd34; seg_in = 6'd56;
    edit_en = 1'b1;
    tick(3);
    mh = 12; mm = 34; ms = 56; mf = 0;
    check_model("load");
    leave_edit("commit1");

    // Blink cadence after entering EDIT
    enter_edit(23, 0, 0);
    chk("blink_k0", blink, blink_exp(0));
    tick(2);
    chk("blink_k2", blink, blink_exp(2));
    tick(1);
    chk("blink_k3", blink, blink_exp(3));
    tick(3);
    chk("blink_k6", blink, blink_exp(6));

    // Wrap cases
    do_press(1, "wrap_up_hora");
    chk("wrap_hora0", hora_out, 0);
    chk("blink_after_step", blink, blink_exp(0));
    tick(3);
    chk("blink_after_step_k3", blink, blink_exp(3));
    do_press(2, "wrap_dn_hora");
    chk("wrap_hora23", hora_out, 23);
    do_press(4, "sel_min");
    do_press(2, "wrap_dn_min");
    chk("wrap_min59", min_out, 59);

    // Field navigation
    do_press(4, "nav_setup1");
    do_press(4, "nav_setup2");
    chk("nav_start", field_sel, 0);
    do_press(4, "nav_der1");
    chk("nav_f1", field_sel, 1);
    do_press(4, "nav_der2");
    chk("nav_f2", field_sel, 2);
    do_press(4, "nav_der3");
    chk("nav_f0", field_sel, 0);
    do_press(8, "nav_izq");
    chk("nav_izq_f2", field_sel, 2);
    do_press(12, "nav_both");
    chk("nav_both_f2", field_sel, 2);
    leave_edit("commit2");

    // Auto-repeat on minutes
    enter_edit(5, 10, 7);
    do_press(4, "rep_sel_min");
    aumento = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (i == 18) aumento = 1'b0;
      cnt = (i >= 1) ? 1 : 0;
      for (int a = D; a <= i; a += R) if (a - 1 <= 18) cnt++;
      chk($sformatf("repeat_min_i%0d", i), min_out, 10 + cnt);
    end
    mm = 14;
    check_model("repeat_end");

    // Simultaneous up+down held: no change
    aumento = 1'b1; disminuye = 1'b1;
    tick(12);
    check_model("updown_held");
    aumento = 1'b0; disminuye = 1'b0;
    tick(2);
    check_model("updown_released");

    // Step and field move together
    do_press(8, "combo_setup");
    do_press(5, "combo_step_move");
    chk("combo_hora", hora_out, 6);
    chk("combo_field", field_sel, 1);

    // Randomized single-press sequence
    for (int n = 0; n < 40; n++) begin
      do_press(masks[$urandom_range(0, 5)], $sformatf("rand%0d", n));
    end
    leave_edit("commit3");

    // Abort by reset during EDIT
    enter_edit(9, 20, 30);
    do_press(1, "abort_pre1");
    do_press(4, "abort_pre2");
    rst = 1'b0;
    #1;
    mh = 0; mm = 0; ms = 0; mf = 0;
    check_model("abort");
    chk("abort_wr", wr_en, 0);
    chk("abort_blink", blink, 1);
    edit_en = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(3);
    chk("abort_wr_count", wr_cnt, exp_wr);
    check_model("abort_after");

    // Buttons in IDLE are ignored
    press(1); press(4); press(2); press(8);
    tick(D + 2);
    check_model("idle_buttons");
    chk("idle_blink", blink, 1);
    chk("idle_wr_count", wr_cnt, exp_wr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/field_edit_controller.md
# field_edit_controller

Sequencing controller for manual time setting. Sits between the button metastability blocks and the time counters. Takes the four debounced button levels and converts them to single-cycle events, with auto-repeat on the up/down buttons. Edits a shadow copy of hours/minutes/seconds field by field, then issues a one-cycle write strobe so the counters load the edited value.

## Interface
Parameters:
- REPEAT_DELAY, 50_000_000: cycles an up/down button must be held after its press event before auto-repeat starts.
- REPEAT_RATE, 10_000_000: cycles between auto-repeat steps.
- BLINK_HALF, 25_000_000: cycles per half-period of the blink output.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- edit_en  in  1  edit-mode switch level (synchronous to clk).
- aumento  in  1  debounced increment button level.
- disminuye  in  1  debounced decrement button level.
- derecha  in  1  debounced next-field button level.
- izquierda  in  1  debounced previous-field button level.
- hora_in  in  5  running hours, 0–23.
- min_in  in  6  running minutes, 0–59.
- seg_in  in  6  running seconds, 0–59.
- field_sel  out  2  selected field: 0 hours, 1 minutes, 2 seconds.
- hora_out  out  5  shadow hours.
- min_out  out  6  shadow minutes.
- seg_out  out  6  shadow seconds.
- wr_en  out  1  one-cycle pulse; counters load *_out.
- blink  out  1  display enable for the selected field.

## Operation
- FSM states: IDLE, LOAD, EDIT, COMMIT.
- IDLE → LOAD when edit_en=1.
- LOAD captures hora_in/min_in/seg_in into the shadow registers and clears field_sel to 0. Unconditionally → EDIT.
- EDIT → COMMIT when edit_en=0.
- COMMIT asserts wr_en. Unconditionally → IDLE.
- Button events are rising edges of each level, one registered previous-value per button.
- derecha event: field_sel 0→1→2→0.
- izquierda event: field_sel 0→2→1→0.
- derecha and izquierda events in the same cycle: both ignored.
- aumento step: selected field +1. Wraps 23→0 for hours and 59→0 for minutes/seconds.
- disminuye step: selected field −1. Wraps 0→23 for hours and 0→59 for minutes/seconds.
- aumento and disminuye both high: no step, and both repeat counters are held at 0.
- Auto-repeat: while exactly one of aumento/disminuye stays high, a step fires REPEAT_DELAY cycles after the press event, then every REPEAT_RATE cycles. Releasing the button clears its counter.
- Step and field-move in the same cycle: the step applies to the old field, and field_sel changes in the same edge.
- Button events outside EDIT are discarded. Repeat counters are held at 0 outside EDIT.
- blink:
  - Forced 1 outside EDIT.
  - In EDIT, toggles every BLINK_HALF cycles.
  - The blink counter resets and blink is forced to 1 on any field change or step, so the edited field is visible immediately.
- Reset or edit_en drop during EDIT:
  - Reset aborts the edit; no wr_en.
  - edit_en drop always commits.

## Timing
- Reset values: state IDLE, field_sel 0, hora/min/seg_out 0, wr_en 0, blink 1, all counters 0.
- Event latency: a button level first sampled high at edge t updates field_sel or the shadow value at edge t+1.
- edit_en sampled high at edge t:
  - LOAD is entered at t.
  - The shadow registers hold the captured values after t+1.
  - The state is EDIT after t+1.
- edit_en sampled low in EDIT at edge t: wr_en is high for the cycle after t+1, then low. The *_out values are stable for that whole cycle and remain so in IDLE.
- Auto-repeat: with the press event at edge t, the first repeat step is at t+REPEAT_DELAY and the next at t+REPEAT_DELAY+REPEAT_RATE.

## Structure
- Shared package holds:
  - field codes FIELD_HORA=0, FIELD_MIN=1, FIELD_SEG=2;
  - limits MAX_HORA=23, MAX_MIN=59;
  - the FSM state encoding.
- Sub-module repeat_pulse: edge detect, delay counter and rate counter. Outputs a one-cycle step. Instantiated for aumento and disminuye. Has an enable input tied to state==EDIT.
- derecha/izquierda use inline edge detection.

## Test plan
Simulation parameters: REPEAT_DELAY=8, REPEAT_RATE=4, BLINK_HALF=3.
- Load/commit: hora_in=12, min_in=34, seg_in=56; raise edit_en, wait 3 cycles, drop it → *_out = 12/34/56, field_sel=0, exactly one wr_en pulse.
- Wrap: in EDIT with field 0 = 23, pulse aumento → hora_out=0. Pulse disminuye → 23. Select minutes at 0, pulse disminuye → 59.
- Field nav: derecha ×3 → field_sel 1,2,0. izquierda ×1 → 2. derecha+izquierda together → unchanged.
- Auto-repeat: hold aumento 20 cycles on min_out=10 → steps at press+1, +8, +12, +16, giving min_out=14. Release → no further steps.
- Simultaneous: aumento+disminuye held together → value unchanged. Press aumento together with derecha on field 0 → hours +1, then field_sel=1.
- Abort: in EDIT after edits, assert rst → all outputs at reset values, no wr_en. Buttons in IDLE → outputs unchanged.
